// File: rtl/pwm_fade_controller.sv
// Breathing/fade sequencer: owns the ena/step/duty inputs of one pwm instance,
// ramping duty between a latched min and max with a hold dwell at each end.
module pwm_fade_controller #(
   parameter int N  = 8,
   parameter int PW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          loop,
   input  logic [PW-1:0] prescale,
   input  logic [15:0]   frame,
   input  logic [N-1:0]  duty_min,
   input  logic [N-1:0]  duty_max,
   input  logic [N-1:0]  rate,
   input  logic [7:0]    hold,
   output logic          ena,
   output logic          step,
   output logic [N-1:0]  duty,
   output logic          busy,
   output logic          done,
   output logic          cfg_err,
   output logic [2:0]    phase
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RAMP_UP = 3'd1,
      HOLD_HI = 3'd2,
      RAMP_DN = 3'd3,
      HOLD_LO = 3'd4
   } state_t;

   state_t        state, state_n;
   logic [N-1:0]  duty_n;
   logic [PW-1:0] pcnt, pcnt_n;
   logic [15:0]   fcnt, fcnt_n;
   logic [7:0]    hcnt, hcnt_n;
   logic          done_n, cfg_err_n, busy_r, accept, upd;

   logic [N-1:0]  c_min, c_max, c_rate;
   logic [7:0]    c_hold;
   logic [PW-1:0] c_pre;
   logic [15:0]   c_frame;
   logic          c_loop;

   logic [N:0]    up_sum, dn_thr;

   // Sums are one bit wider so a ramp near full scale saturates instead of wrapping
   assign up_sum = {1'b0, duty} + {1'b0, c_rate};
   assign dn_thr = {1'b0, c_min} + {1'b0, c_rate};

   assign step    = (state != IDLE) && (pcnt == c_pre);
   assign upd     = step && (fcnt == c_frame);
   assign ena     = busy_r;
   assign busy    = busy_r;
   assign phase   = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         c_min   <= '0;
         c_max   <= '0;
         c_rate  <= '0;
         c_hold  <= '0;
         c_pre   <= '0;
         c_frame <= '0;
         c_loop  <= 1'b0;
      end else if (accept) begin
         c_min   <= duty_min;
         c_max   <= duty_max;
         c_rate  <= (rate == '0) ? N'(1) : rate;
         c_hold  <= hold;
         c_pre   <= prescale;
         c_frame <= frame;
         c_loop  <= loop;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         duty    <= '0;
         pcnt    <= '0;
         fcnt    <= '0;
         hcnt    <= '0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state   <= state_n;
         duty    <= duty_n;
         pcnt    <= pcnt_n;
         fcnt    <= fcnt_n;
         hcnt    <= hcnt_n;
         done    <= done_n;
         cfg_err <= cfg_err_n;
         busy_r  <= (state_n != IDLE);
      end
   end

   always_comb begin
      state_n   = state;
      duty_n    = duty;
      pcnt_n    = pcnt;
      fcnt_n    = fcnt;
      hcnt_n    = hcnt;
      done_n    = 1'b0;
      cfg_err_n = 1'b0;
      accept    = 1'b0;
      if (state == IDLE) begin
         if (start && !stop) begin
            if (duty_min >= duty_max) begin
               cfg_err_n = 1'b1;
            end else begin
               accept  = 1'b1;
               state_n = RAMP_UP;
               duty_n  = duty_min;
               pcnt_n  = '0;
               fcnt_n  = '0;
               hcnt_n  = '0;
            end
         end
      end else if (stop) begin
         state_n = IDLE;
         duty_n  = '0;
         pcnt_n  = '0;
         fcnt_n  = '0;
         hcnt_n  = '0;
      end else begin
         if (step) begin
            pcnt_n = '0;
            fcnt_n = upd ? 16'd0 : fcnt + 16'd1;
         end else begin
            pcnt_n = pcnt + PW'(1);
         end
         // Duty and state only move on update events
         if (upd) begin
            case (state)
               RAMP_UP: begin
                  if (up_sum >= {1'b0, c_max}) begin
                     duty_n  = c_max;
                     state_n = HOLD_HI;
                     hcnt_n  = '0;
                  end else begin
                     duty_n = up_sum[N-1:0];
                  end
               end
               HOLD_HI: begin
                  if (hcnt == c_hold) begin
                     state_n = RAMP_DN;
                     hcnt_n  = '0;
                  end else begin
                     hcnt_n = hcnt + 8'd1;
                  end
               end
               RAMP_DN: begin
                  if ({1'b0, duty} <= dn_thr) begin
                     duty_n  = c_min;
                     state_n = HOLD_LO;
                     hcnt_n  = '0;
                  end else begin
                     duty_n = duty - c_rate;
                  end
               end
               HOLD_LO: begin
                  if (hcnt == c_hold) begin
                     hcnt_n = '0;
                     if (c_loop) begin
                        state_n = RAMP_UP;
                     end else begin
                        state_n = IDLE;
                        duty_n  = '0;
                        done_n  = 1'b1;
                        pcnt_n  = '0;
                        fcnt_n  = '0;
                     end
                  end else begin
                     hcnt_n = hcnt + 8'd1;
                  end
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Scoreboard bench: a trajectory model predicts visible duty/phase events and
// step cycles; a negedge monitor pops and compares whatever the DUT shows.
module tb_pwm_fade_controller;
   localparam int N  = 8;
   localparam int PW = 16;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
   logic [PW-1:0] prescale = '0;
   logic [15:0]   frame = '0;
   logic [N-1:0]  duty_min = '0, duty_max = '0, rate = '0;
   logic [7:0]    hold = '0;
   logic          ena, step, busy, done, cfg_err;
   logic [N-1:0]  duty;
   logic [2:0]    phase;

   int total = 0, bad = 0, cyc = 0;
   int step_cnt = 0, done_cnt = 0, done_cyc = -1;
   bit mon_en = 1'b0;

   typedef struct {
      int         cyc;
      logic [7:0] duty;
      logic [2:0] phase;
      logic       act;
      logic       done;
      logic       cfg_err;
   } ev_t;

   typedef struct {
      int duty;
      int phase;
      bit done;
   } pt_t;

   ev_t exp_q[$];
   int  step_q[$];
   pt_t prof[$];

   pwm_fade_controller #(.N(N), .PW(PW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
      .prescale(prescale), .frame(frame), .duty_min(duty_min), .duty_max(duty_max),
      .rate(rate), .hold(hold), .ena(ena), .step(step), .duty(duty), .busy(busy),
      .done(done), .cfg_err(cfg_err), .phase(phase)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_ev(input int c, input int d, input int ph, input bit dn, input bit ce);
      ev_t e;
      e.cyc     = c;
      e.duty    = 8'(d);
      e.phase   = 3'(ph);
      e.act     = (ph != 0);
      e.done    = dn;
      e.cfg_err = ce;
      exp_q.push_back(e);
   endtask

   task automatic push_pt(input int d, input int ph, input bit dn);
      pt_t p;
      p.duty  = d;
      p.phase = ph;
      p.done  = dn;
      prof.push_back(p);
   endtask

   // Trajectory of (duty, phase) after each update event, from the ramp/hold rules
   task automatic build_profile(input int mn, input int mx, input int rt, input int hd, input bit lp);
      int r, d, periods;
      r = (rt == 0) ? 1 : rt;
      periods = lp ? 3 : 1;
      prof.delete();
      for (int p = 0; p < periods; p++) begin
         d = mn;
         while (d + r < mx) begin
            d += r;
            push_pt(d, 1, 1'b0);
         end
         push_pt(mx, 2, 1'b0);
         for (int h = 0; h < hd; h++) push_pt(mx, 2, 1'b0);
         push_pt(mx, 3, 1'b0);
         d = mx;
         while (d > mn + r) begin
            d -= r;
            push_pt(d, 3, 1'b0);
         end
         push_pt(mn, 4, 1'b0);
         for (int h = 0; h < hd; h++) push_pt(mn, 4, 1'b0);
         if (lp) push_pt(mn, 1, 1'b0);
         else    push_pt(0, 0, 1'b1);
      end
   endtask

   task automatic build_events(input int s, input int pre, input int frm, input int mn,
                               input int cut, output int last_busy);
      int pf, c, pd, pph;
      pf = (pre + 1) * (frm + 1);
      push_ev(s + 1, mn, 1, 1'b0, 1'b0);
      pd = mn;
      pph = 1;
      for (int k = 1; k <= prof.size(); k++) begin
         c = s + k * pf + 1;
         if (cut >= 0 && c > cut) break;
         if (prof[k-1].duty != pd || prof[k-1].phase != pph || prof[k-1].done)
            push_ev(c, prof[k-1].duty, prof[k-1].phase, prof[k-1].done, 1'b0);
         pd = prof[k-1].duty;
         pph = prof[k-1].phase;
      end
      if (cut >= 0) begin
         push_ev(cut + 1, 0, 0, 1'b0, 1'b0);
         last_busy = cut;
      end else begin
         last_busy = s + prof.size() * pf;
      end
      for (int sc = s + pre + 1; sc <= last_busy; sc += pre + 1) step_q.push_back(sc);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic scramble_inputs();
      prescale = PW'($urandom_range(0, 7));
      frame    = 16'($urandom_range(0, 7));
      duty_min = 8'($urandom);
      duty_max = 8'($urandom);
      rate     = 8'($urandom);
      hold     = 8'($urandom_range(0, 5));
      loop     = 1'($urandom);
   endtask

   // One accepted sequence; cut_rel >= 0 ends it with stop (or rst) in cycle s+cut_rel
   task automatic apply_stimulus(input int pre, input int frm, input int mn, input int mx,
                                 input int rt, input int hd, input bit lp, input int cut_rel,
                                 input bit cut_rst, input bit poke_busy, output int s);
      int last_busy, cut;
      prescale = PW'(pre);
      frame    = 16'(frm);
      duty_min = 8'(mn);
      duty_max = 8'(mx);
      rate     = 8'(rt);
      hold     = 8'(hd);
      loop     = lp;
      start    = 1'b1;
      s = cyc;
      cut = (cut_rel >= 0) ? s + cut_rel : -1;
      build_profile(mn, mx, rt, hd, lp);
      build_events(s, pre, frm, mn, cut, last_busy);
      @(posedge clk);
      #1;
      start = 1'b0;
      scramble_inputs();
      if (poke_busy && cut < 0 && last_busy >= s + 3) begin
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      if (cut >= 0) begin
         wait_until(cut);
         if (cut_rst) rst = 1'b1;
         else         stop = 1'b1;
         @(posedge clk);
         #1;
         rst  = 1'b0;
         stop = 1'b0;
      end
      wait_until(last_busy + 3);
   endtask

   // Scoreboard monitor: compares whenever the DUT shows a change or a pulse
   logic [7:0] p_duty = '0;
   logic [2:0] p_phase = '0;
   logic       p_act = 1'b0;
   int         exp_s;
   ev_t        e;

   always @(negedge clk) begin
      if (mon_en) begin
         while (step_q.size() > 0 && step_q[0] < cyc) begin
            check_output($sformatf("step_missing_c%0d", step_q[0]), 0, 1);
            void'(step_q.pop_front());
         end
         if (step === 1'b1) begin
            step_cnt++;
            exp_s = (step_q.size() > 0) ? step_q[0] : -1;
            check_output("step_cycle", cyc, exp_s);
            if (exp_s == cyc) void'(step_q.pop_front());
         end
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check_output($sformatf("event_missing_c%0d", exp_q[0].cyc), 0, 1);
            void'(exp_q.pop_front());
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (duty !== p_duty || phase !== p_phase || ena !== p_act ||
             done !== 1'b0 || cfg_err !== 1'b0) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               e = exp_q.pop_front();
               check_output("duty", duty, e.duty);
               check_output("phase", phase, e.phase);
               check_output("ena", ena, e.act);
               check_output("busy", busy, e.act);
               check_output("done", done, e.done);
               check_output("cfg_err", cfg_err, e.cfg_err);
            end else begin
               check_output("unexpected_event_cycle", cyc,
                            (exp_q.size() > 0) ? exp_q[0].cyc : -1);
            end
         end
         p_duty  = duty;
         p_phase = phase;
         p_act   = ena;
      end
   end

   initial begin
      #3_000_000;
      bad++;
      $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int s, pre, frm, mn, mx, rt, hd, pf, cut_rel, dc0, sc0;
      bit lp, crst;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_output("rst_duty", duty, 0);
      check_output("rst_phase", phase, 0);
      check_output("rst_ena", ena, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_cfg_err", cfg_err, 0);
      check_output("rst_step", step, 0);
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      sc0 = step_cnt;
      apply_stimulus(1, 0, 10, 40, 10, 1, 1'b0, -1, 1'b0, 1'b0, s);
      check_output("oneshot_done_cycle", done_cyc - s, 21);
      check_output("oneshot_step_count", step_cnt - sc0, 10);

      apply_stimulus(0, 0, 10, 200, 10, 0, 1'b0, 3, 1'b1, 1'b0, s);
      apply_stimulus(0, 0, 10, 200, 10, 0, 1'b0, 6, 1'b0, 1'b0, s);

      apply_stimulus(0, 1, 250, 255, 10, 0, 1'b0, -1, 1'b0, 1'b1, s);

      dc0 = done_cnt;
      apply_stimulus(0, 0, 10, 40, 10, 2, 1'b1, 17, 1'b0, 1'b0, s);
      check_output("loop_no_done", done_cnt - dc0, 0);

      apply_stimulus(0, 3, 0, 10, 0, 0, 1'b0, -1, 1'b0, 1'b0, s);

      duty_min = 8'd40;
      duty_max = 8'd40;
      start = 1'b1;
      push_ev(cyc + 1, 0, 0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      start = 1'b0;
      check_output("cfgerr_pulse", cfg_err, 1);
      check_output("cfgerr_idle", busy, 0);
      @(posedge clk);
      #1;
      check_output("cfgerr_one_cycle", cfg_err, 0);

      duty_min = 8'd10;
      duty_max = 8'd40;
      start = 1'b1;
      stop = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop = 1'b0;
      check_output("start_stop_busy", busy, 0);
      check_output("start_stop_phase", phase, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         pre = $urandom_range(0, 3);
         frm = $urandom_range(0, 3);
         mn  = $urandom_range(0, 200);
         mx  = mn + 1 + $urandom_range(0, 40);
         rt  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
         hd  = $urandom_range(0, 3);
         lp  = 1'($urandom);
         crst = 1'($urandom);
         pf  = (pre + 1) * (frm + 1);
         cut_rel = lp ? $urandom_range(1, 12 * pf - 1) : -1;
         apply_stimulus(pre, frm, mn, mx, rt, hd, lp, cut_rel, crst, 1'b1, s);
      end

      repeat (5) @(posedge clk);
      #1;
      check_output("leftover_events", exp_q.size(), 0);
      check_output("leftover_steps", step_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
